rv32i_mem_arbiter: RTL and testbench

- Shares one single-port memory between the CPU's instruction-fetch path and its load/store path.
- Lets the core's separate `instruction` and `from_memory`/`memory_address` interfaces run against one unified RAM.
- Serialises accesses and alternates priority when both requesters contend.
- Returns one-cycle acknowledges with registered read data, and aborts hung accesses with an error after a programmable timeout.

---
 rtl/rv32i_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_mem_arbiter
// Description : Two-requester (fetch / load-store) arbiter onto one
//               single-port memory, alternating priority, with access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit               c_TO_EN    = (TIMEOUT != 0);

  state_t           r_state;
  logic             r_last_d;
  logic [CNT_W-1:0] r_cnt;

  logic w_if_elig;
  logic w_d_elig;
  logic w_grant_d;
  logic w_grant_if;
  logic w_timeout;
  logic w_unused_addr_bits;

  // A requester still holding req during its own ack cycle must not re-win.
  assign w_if_elig  = if_req & ~if_ack;
  assign w_d_elig   = d_req & ~d_ack;
  assign w_grant_d  = w_d_elig & (~w_if_elig | ~r_last_d);
  assign w_grant_if = w_if_elig & ~w_grant_d;
  assign w_timeout  = c_TO_EN && (r_cnt == c_CNT_LAST);

  assign w_unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_cnt     <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= {d_addr[31:2], 2'b00};
            mem_wdata <= d_wdata;
            r_cnt     <= '0;
            r_last_d  <= 1'b1;
            r_state   <= BUSY_D;
          end else if (w_grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[31:2], 2'b00};
            r_cnt     <= '0;
            r_last_d  <= 1'b0;
            r_state   <= BUSY_IF;
          end
        end
        BUSY_IF, BUSY_D: begin
          // mem_ready takes precedence over an expiring timeout
          if (mem_ready || w_timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= ~mem_ready;
            r_state <= IDLE;
            if (r_state == BUSY_D) begin
              d_ack <= 1'b1;
              if (!mem_ready)
                d_rdata <= '0;
              else if (!mem_we)
                d_rdata <= mem_rdata;
            end else begin
              if_ack <= 1'b1;
              if (!mem_ready)
                if_rdata <= '0;
              else
                if_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_mem_arbiter
// Description : Directed and randomized self-checking bench for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_arbiter;

  logic        sys_clk;
  logic        sys_reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, err, mem_req, mem_we;

  logic        t_if_req, t_d_req, t_d_we, t_mem_ready;
  logic [31:0] t_if_addr, t_d_addr, t_d_wdata, t_mem_rdata;
  logic [31:0] t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_if_ack, t_d_ack, t_err, t_mem_req, t_mem_we;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram   [0:255];
  logic [31:0] model [0:255];
  int          busy_cnt, resp_wait;
  bit          rand_mode;

  rv32i_mem_arbiter #(.TIMEOUT(32), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  rv32i_mem_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut_t (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .if_req(t_if_req), .if_addr(t_if_addr), .if_rdata(t_if_rdata), .if_ack(t_if_ack),
    .d_req(t_d_req), .d_we(t_d_we), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
    .d_rdata(t_d_rdata), .d_ack(t_d_ack), .err(t_err),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(t_mem_rdata), .mem_ready(t_mem_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] bit32(input logic x);
    return {31'd0, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge, then play the memory for the main DUT.
  task automatic tick();
    @(negedge sys_clk);
    if (mem_req) begin
      check("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      if (busy_cnt == 0 && rand_mode) resp_wait = $urandom_range(0, 3);
      if (busy_cnt == resp_wait) begin
        mem_ready = 1'b1;
        mem_rdata = ram[mem_addr[9:2]];
        if (mem_we) ram[mem_addr[9:2]] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      busy_cnt++;
    end else begin
      busy_cnt  = 0;
      mem_ready = rand_mode & 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  endtask

  initial begin
    logic [2:0]  order;
    logic [31:0] v, d_exp, d_wd;
    logic [7:0]  if_idx, d_idx;
    int          nacks, both, nreq, ack_k, t_nreq, if_age, d_age, max_age, n_acks;
    bit          acked, t_acked, if_pend, d_pend, d_we_l;

    sys_reset = 1'b1; rand_mode = 1'b0; resp_wait = 0; busy_cnt = 0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    t_if_req = 0; t_if_addr = 0; t_d_req = 0; t_d_we = 0; t_d_addr = 0; t_d_wdata = 0;
    t_mem_ready = 0; t_mem_rdata = 0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; ram[i] = v; model[i] = v;
    end
    ram[4] = 32'h13; model[4] = 32'h13;

    tick(); tick();
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_ctl", {27'd0, if_ack, d_ack, err, mem_req, mem_we}, 32'd0);

    // Single fetch
    sys_reset = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    tick();
    check("fetch_mem_req", bit32(mem_req), 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h10);
    check("fetch_mem_we", bit32(mem_we), 32'd0);
    check("fetch_early_ack", bit32(if_ack), 32'd0);
    tick();
    check("fetch_ack", bit32(if_ack), 32'd1);
    check("fetch_rdata", if_rdata, 32'h13);
    check("fetch_err", bit32(err), 32'd0);
    check("fetch_req_drop", bit32(mem_req), 32'd0);
    if_req = 1'b0;
    tick();
    check("fetch_ack_pulse", bit32(if_ack), 32'd0);

    // Contention right after reset: D, IF, D
    sys_reset = 1'b1; tick(); sys_reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    nacks = 0; both = 0; order = 3'b000;
    for (int k = 0; k < 30 && nacks < 3; k++) begin
      tick();
      if (if_ack && d_ack) both++;
      if (if_ack || d_ack) begin
        order[nacks] = d_ack;
        if (if_ack) check("cont_if_rdata", if_rdata, model[8]);
        if (d_ack)  check("cont_d_rdata", d_rdata, model[9]);
        nacks++;
        if (nacks == 3) begin if_req = 1'b0; d_req = 1'b0; end
      end
    end
    check("cont_nacks", nacks, 32'd3);
    check("cont_overlap", both, 32'd0);
    check("cont_order", {29'd0, order}, 32'h5);
    tick();

    // Store keeps d_rdata
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h103; d_wdata = 32'hDEADBEEF;
    tick();
    check("st_mem_addr", mem_addr, 32'h100);
    check("st_mem_we", bit32(mem_we), 32'd1);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    check("st_ack", bit32(d_ack), 32'd1);
    check("st_d_rdata", d_rdata, model[9]);
    d_req = 1'b0; d_we = 1'b0; model[64] = 32'hDEADBEEF;
    check("st_ram", ram[64], model[64]);
    tick();

    // Wait states with address scribbled mid-access
    resp_wait = 5; d_req = 1'b1; d_addr = 32'h40;
    nreq = 0; acked = 0; ack_k = -1;
    for (int k = 0; k < 12 && !acked; k++) begin
      tick();
      if (mem_req) begin nreq++; check("ws_addr", mem_addr, 32'h40); end
      if (k == 2) d_addr = 32'hFFFF_FFF0;
      if (d_ack) begin
        acked = 1; ack_k = k;
        check("ws_rdata", d_rdata, model[16]);
        d_req = 1'b0;
      end
    end
    check("ws_req_cycles", nreq, 32'd6);
    check("ws_ack_cycle", ack_k, 32'd6);
    resp_wait = 0;
    tick();

    // Timeout (TIMEOUT=4 instance): good fetch, then a hung fetch, then a store
    t_if_req = 1'b1; t_if_addr = 32'h8;
    tick(); t_mem_ready = 1'b1; t_mem_rdata = 32'hABCD0123;
    tick();
    check("to_first_ack", bit32(t_if_ack), 32'd1);
    check("to_first_rdata", t_if_rdata, 32'hABCD0123);
    t_if_req = 1'b0; t_mem_ready = 1'b0;
    tick();
    t_if_req = 1'b1; t_if_addr = 32'hC; t_nreq = 0; t_acked = 0;
    for (int k = 0; k < 12 && !t_acked; k++) begin
      tick();
      if (t_mem_req) t_nreq++;
      if (k == 1) begin t_d_req = 1'b1; t_d_we = 1'b1; t_d_addr = 32'h44; t_d_wdata = 32'h12345678; end
      if (t_if_ack) begin
        t_acked = 1;
        check("to_err", bit32(t_err), 32'd1);
        check("to_rdata", t_if_rdata, 32'd0);
        check("to_req_cycles", t_nreq, 32'd4);
        check("to_no_d_ack", bit32(t_d_ack), 32'd0);
        t_if_req = 1'b0;
      end
    end
    check("to_acked", bit32(t_acked), 32'd1);
    tick();
    check("to_d_grant", bit32(t_mem_req), 32'd1);
    check("to_d_addr", t_mem_addr, 32'h44);
    check("to_d_we", bit32(t_mem_we), 32'd1);
    check("to_d_wdata", t_mem_wdata, 32'h12345678);
    t_mem_ready = 1'b1;
    tick();
    check("to_d_ack", bit32(t_d_ack), 32'd1);
    check("to_d_err", bit32(t_err), 32'd0);
    t_d_req = 1'b0; t_mem_ready = 1'b0;

    // Reset in the middle of a data access
    resp_wait = 20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick();
    check("rm_busy", bit32(mem_req), 32'd1);
    tick(); sys_reset = 1'b1;
    tick();
    check("rm_ctl", {27'd0, if_ack, d_ack, err, mem_req, mem_we}, 32'd0);
    check("rm_d_rdata", d_rdata, 32'd0);
    check("rm_mem_addr", mem_addr, 32'd0);
    sys_reset = 1'b0; resp_wait = 0;
    tick();
    check("rm_regrant", bit32(mem_req), 32'd1);
    check("rm_regrant_addr", mem_addr, 32'h80);
    tick();
    check("rm_ack", bit32(d_ack), 32'd1);
    check("rm_rdata", d_rdata, model[32]);
    d_req = 1'b0;

    // Randomized traffic against a transaction-level memory model
    sys_reset = 1'b1; tick(); sys_reset = 1'b0;
    rand_mode = 1'b1; if_pend = 0; d_pend = 0; if_age = 0; d_age = 0;
    max_age = 0; n_acks = 0; d_exp = 32'd0; if_idx = 0; d_idx = 0; d_wd = 0; d_we_l = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      check("rnd_ack_overlap", bit32(if_ack & d_ack), 32'd0);
      check("rnd_err", bit32(err), 32'd0);
      if (if_ack) begin
        check("rnd_if_spurious", bit32(if_pend), 32'd1);
        check("rnd_if_rdata", if_rdata, model[if_idx]);
        if_pend = 0; if_req = 1'b0; n_acks++;
      end
      if (d_ack) begin
        check("rnd_d_spurious", bit32(d_pend), 32'd1);
        if (d_we_l) model[d_idx] = d_wd;
        else        d_exp = model[d_idx];
        check("rnd_d_rdata", d_rdata, d_exp);
        d_pend = 0; d_req = 1'b0; n_acks++;
      end
      if (if_pend) begin if_age++; if (if_age > max_age) max_age = if_age; end
      if (d_pend)  begin d_age++;  if (d_age > max_age)  max_age = d_age;  end
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1; if_age = 0;
        if_addr = {22'd0, 10'($urandom)}; if_idx = if_addr[9:2]; if_req = 1'b1;
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; d_age = 0;
        d_addr = {22'd0, 10'($urandom)}; d_idx = d_addr[9:2];
        d_we_l = 1'($urandom_range(0, 1)); d_we = d_we_l;
        d_wd = $urandom; d_wdata = d_wd; d_req = 1'b1;
      end
    end
    check("rnd_latency_bound", bit32(max_age <= 40), 32'd1);
    check("rnd_progress", bit32(n_acks > 50), 32'd1);
    rand_mode = 1'b0; if_req = 1'b0; d_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
